// File: rtl/onchip_ram_tester.sv
// Avalon-MM master that fills a RAM region with a seed-derived pattern and/or
// reads it back, counting mismatches and remembering the first failing address.
module onchip_ram_tester #(
  parameter int ADDR_W      = 15,
  parameter int CNT_W       = 14,
  parameter int MAX_PENDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic [15:0]       error_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              first_err_valid,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam int                PEND_W    = $clog2(MAX_PENDING + 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;
  state_t state_reg, state_next;

  logic              verify_reg;
  logic [ADDR_W-1:0] base_reg, addr_reg, rx_addr_reg, first_addr_reg;
  logic [CNT_W-1:0]  count_reg, idx_reg, rx_idx_reg, idx_inc;
  logic [31:0]       val_reg, rx_val_reg, rx_expect;
  logic [PEND_W-1:0] pend_reg, pend_next;
  logic              gap_reg, first_valid_reg;
  logic [15:0]       err_reg;
  logic              wr_acc, rd_acc, rdv_take, last_issue;

  assign wr_acc     = avm_write & ~avm_waitrequest;
  assign rd_acc     = avm_read & ~avm_waitrequest;
  // Read data is only meaningful while reads of this operation are in flight.
  assign rdv_take   = avm_readdatavalid && (state_reg == S_READ || state_reg == S_DRAIN)
                      && (pend_reg != '0);
  assign idx_inc    = idx_reg + CNT_W'(1);
  assign last_issue = (idx_inc == count_reg);
  assign rx_expect  = rx_idx_reg[0] ? ~rx_val_reg : rx_val_reg;

  assign avm_address     = addr_reg;
  assign avm_writedata   = idx_reg[0] ? ~val_reg : val_reg;
  assign avm_byteenable  = 4'b1111;
  assign error_count     = err_reg;
  assign first_err_addr  = first_addr_reg;
  assign first_err_valid = first_valid_reg;

  always_comb begin
    pend_next = pend_reg;
    if (rd_acc && !rdv_take)
      pend_next = pend_reg + PEND_W'(1);
    else if (!rd_acc && rdv_take)
      pend_next = pend_reg - PEND_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          // An empty request passes through DRAIN, which finds nothing pending.
          if (word_count == '0)
            state_next = S_DRAIN;
          else if (mode == 2'd2)
            state_next = S_READ;
          else
            state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wr_acc && last_issue)
          state_next = verify_reg ? S_READ : S_DONE;
      end
      S_READ: begin
        if (rd_acc && last_issue)
          state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (pend_next == '0)
          state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    avm_write = (state_reg == S_WRITE);
    avm_read  = (state_reg == S_READ) && !gap_reg && (idx_reg < count_reg)
                && (pend_reg < PEND_MAX);
    busy      = (state_reg != S_IDLE);
    done      = (state_reg == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      verify_reg      <= 1'b0;
      base_reg        <= '0;
      addr_reg        <= '0;
      rx_addr_reg     <= '0;
      count_reg       <= '0;
      idx_reg         <= '0;
      rx_idx_reg      <= '0;
      val_reg         <= '0;
      rx_val_reg      <= '0;
      pend_reg        <= '0;
      gap_reg         <= 1'b0;
      err_reg         <= '0;
      first_valid_reg <= 1'b0;
      first_addr_reg  <= '0;
    end else begin
      pend_reg <= pend_next;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            verify_reg      <= (mode != 2'd0);
            base_reg        <= base_addr & WORD_MASK;
            addr_reg        <= base_addr & WORD_MASK;
            rx_addr_reg     <= base_addr & WORD_MASK;
            count_reg       <= word_count;
            idx_reg         <= '0;
            rx_idx_reg      <= '0;
            val_reg         <= seed;
            rx_val_reg      <= seed;
            gap_reg         <= 1'b0;
            err_reg         <= '0;
            first_valid_reg <= 1'b0;
            first_addr_reg  <= '0;
          end
        end
        S_WRITE: begin
          if (wr_acc) begin
            if (last_issue) begin
              // Rewind the issue side for the read pass; gap_reg holds off one cycle.
              idx_reg  <= '0;
              addr_reg <= base_reg;
              gap_reg  <= 1'b1;
            end else begin
              idx_reg  <= idx_inc;
              addr_reg <= addr_reg + ADDR_STEP;
              val_reg  <= val_reg + 32'd1;
            end
          end
        end
        S_READ: begin
          gap_reg <= 1'b0;
          if (rd_acc) begin
            idx_reg  <= idx_inc;
            addr_reg <= addr_reg + ADDR_STEP;
          end
        end
        default: ;
      endcase

      if (rdv_take) begin
        rx_idx_reg  <= rx_idx_reg + CNT_W'(1);
        rx_val_reg  <= rx_val_reg + 32'd1;
        rx_addr_reg <= rx_addr_reg + ADDR_STEP;
        if (avm_readdata != rx_expect) begin
          if (err_reg != 16'hFFFF)
            err_reg <= err_reg + 16'd1;
          if (!first_valid_reg) begin
            first_valid_reg <= 1'b1;
            first_addr_reg  <= rx_addr_reg;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_onchip_ram_tester.sv
// Bench for onchip_ram_tester: randomized Avalon slave with stalls and latency,
// per-operation reference of addresses, patterns and expected verify results.
module tb_onchip_ram_tester;
  localparam int MAXP = 4;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  mode;
  logic [14:0] base_addr;
  logic [13:0] word_count;
  logic [31:0] seed;
  logic        busy, done, first_err_valid;
  logic [15:0] error_count;
  logic [14:0] first_err_addr, avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_write, avm_read, avm_waitrequest, avm_readdatavalid;
  logic [31:0] avm_writedata, avm_readdata;

  onchip_ram_tester #(.ADDR_W(15), .CNT_W(14), .MAX_PENDING(MAXP)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr),
    .word_count(word_count), .seed(seed), .busy(busy), .done(done),
    .error_count(error_count), .first_err_addr(first_err_addr),
    .first_err_valid(first_err_valid), .avm_address(avm_address),
    .avm_byteenable(avm_byteenable), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] s, input int i);
    logic [31:0] v;
    v = s + 32'(i);
    return i[0] ? ~v : v;
  endfunction

  function automatic logic [14:0] waddr(input logic [14:0] b, input int i);
    return (b & 15'h7FFC) + 15'(4 * i);
  endfunction

  // Slave memory plus a read-side corruption mask owned by the stimulus side.
  logic [31:0] mem   [8192];
  logic [31:0] xmask [8192];

  typedef struct packed { logic [31:0] data; int due; } rsp_t;
  rsp_t        rsp_q[$];
  logic [14:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [14:0] rd_addr_q[$];
  int wait_pct = 0, lat_min = 1, lat_max = 1;
  int op_id = 0;
  int acc_cnt, rv_cnt, done_cnt, bus_cycles, first_req_edge, last_wr_edge, last_rdv_edge;

  // Slave + monitor: at each negedge decide this edge's response/stall and log accepts.
  initial begin
    int mon_op, last_due, due;
    logic        stalled_prev, rdv_now;
    logic [48:0] held;
    mon_op = 0; last_due = 0; stalled_prev = 1'b0; held = '0;
    acc_cnt = 0; rv_cnt = 0; done_cnt = 0; bus_cycles = 0;
    first_req_edge = -1; last_wr_edge = -1; last_rdv_edge = -1;
    for (int k = 0; k < 8192; k++) mem[k] = '0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    forever begin
      @(negedge clk);
      if (op_id != mon_op) begin
        mon_op = op_id;
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        acc_cnt = 0; rv_cnt = 0; done_cnt = 0; bus_cycles = 0;
        first_req_edge = -1; last_wr_edge = -1; last_rdv_edge = -1;
      end
      rdv_now = 1'b0;
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc + 1) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = rsp_q[0].data;
        void'(rsp_q.pop_front());
        rdv_now       = 1'b1;
        last_rdv_edge = cyc + 1;
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata      = $urandom;
      end
      if (reset)
        stalled_prev = 1'b0;
      else if (stalled_prev)
        check_eq("stall_hold", 64'({avm_write, avm_read, avm_address, avm_writedata}), 64'(held));
      avm_waitrequest = ($urandom_range(99) < wait_pct);
      if (avm_write || avm_read) begin
        bus_cycles++;
        check_eq("byteenable", 64'(avm_byteenable), 64'hF);
      end
      stalled_prev = !reset && (avm_write || avm_read) && avm_waitrequest;
      held = {avm_write, avm_read, avm_address, avm_writedata};
      if (avm_write && !avm_waitrequest) begin
        wr_addr_q.push_back(avm_address);
        wr_data_q.push_back(avm_writedata);
        mem[avm_address[14:2]] = avm_writedata;
        if (first_req_edge < 0) first_req_edge = cyc + 1;
        last_wr_edge = cyc + 1;
      end
      if (avm_read && !avm_waitrequest) begin
        rd_addr_q.push_back(avm_address);
        acc_cnt++;
        if (first_req_edge < 0) first_req_edge = cyc + 1;
        check_eq("max_pending", 64'(acc_cnt - rv_cnt <= MAXP), 64'd1);
        due = cyc + 1 + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        rsp_q.push_back('{data: mem[avm_address[14:2]] ^ xmask[avm_address[14:2]], due: due});
      end
      if (rdv_now) rv_cnt++;
      if (done) done_cnt++;
    end
  end

  logic [1:0]  e_mode;
  logic [14:0] e_base;
  int          e_cnt, s_cyc, d_cyc;
  logic [31:0] e_seed;

  task automatic settle();
    int k;
    k = 0;
    while ((rsp_q.size() > 0 || busy) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq("settle_timeout", 64'(rsp_q.size() == 0 && !busy), 64'd1);
  endtask

  task automatic start_op(input logic [1:0] m, input logic [14:0] b, input int n,
                          input logic [31:0] s);
    settle();
    e_mode = m; e_base = b; e_cnt = n; e_seed = s;
    @(posedge clk); #1;
    op_id++;
    mode = m; base_addr = b; word_count = 14'(n); seed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; s_cyc = cyc;
    mode = 2'($urandom); base_addr = 15'($urandom); word_count = 14'($urandom); seed = $urandom;
  endtask

  task automatic wait_done(input string tag);
    bit got;
    got = 1'b0;
    @(negedge clk);
    check_eq({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    for (int k = 0; k < 3000 && !got; k++) begin
      if (done) begin
        got = 1'b1;
        d_cyc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      check_eq({tag, "_done_timeout"}, 64'd0, 64'd1);
    end else begin
      check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd1);
      @(negedge clk);
      check_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
      check_eq({tag, "_idle_after"}, 64'(busy), 64'd0);
    end
  endtask

  task automatic check_op(input string tag);
    bit          w, v;
    int          ne, nw, nr;
    logic [14:0] fa, a;
    w = (e_mode != 2'd2);
    v = (e_mode != 2'd0);
    ne = 0; fa = '0;
    nw = wr_addr_q.size();
    nr = rd_addr_q.size();
    check_eq({tag, "_wr_count"}, 64'(nw), 64'(w ? e_cnt : 0));
    check_eq({tag, "_rd_count"}, 64'(nr), 64'(v ? e_cnt : 0));
    for (int i = 0; i < nw && i < e_cnt; i++) begin
      check_eq({tag, "_wr_addr"}, 64'(wr_addr_q[i]), 64'(waddr(e_base, i)));
      check_eq({tag, "_wr_data"}, 64'(wr_data_q[i]), 64'(pat(e_seed, i)));
    end
    for (int i = 0; i < nr && i < e_cnt; i++)
      check_eq({tag, "_rd_addr"}, 64'(rd_addr_q[i]), 64'(waddr(e_base, i)));
    if (v) begin
      for (int i = 0; i < e_cnt; i++) begin
        a = waddr(e_base, i);
        if ((mem[a[14:2]] ^ xmask[a[14:2]]) !== pat(e_seed, i)) begin
          if (ne == 0) fa = a;
          ne++;
        end
      end
    end
    check_eq({tag, "_err_count"}, 64'(error_count), 64'(ne));
    check_eq({tag, "_first_valid"}, 64'(first_err_valid), 64'(ne != 0));
    if (ne != 0) check_eq({tag, "_first_addr"}, 64'(first_err_addr), 64'(fa));
    check_eq({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    if (e_cnt > 0)
      check_eq({tag, "_done_timing"}, 64'(d_cyc), 64'(v ? last_rdv_edge : last_wr_edge));
    $display("op %s mode=%0d base=%h count=%0d seed=%h writes=%0d reads=%0d errors=%0d first=%h/%0d",
             tag, e_mode, e_base, e_cnt, e_seed, nw, nr, error_count, first_err_addr,
             first_err_valid);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
    check_eq({tag, "_write"}, 64'(avm_write), 64'd0);
    check_eq({tag, "_read"}, 64'(avm_read), 64'd0);
    check_eq({tag, "_address"}, 64'(avm_address), 64'd0);
    check_eq({tag, "_writedata"}, 64'(avm_writedata), 64'd0);
    check_eq({tag, "_byteenable"}, 64'(avm_byteenable), 64'hF);
    check_eq({tag, "_err_count"}, 64'(error_count), 64'd0);
    check_eq({tag, "_first_valid"}, 64'(first_err_valid), 64'd0);
    check_eq({tag, "_first_addr"}, 64'(first_err_addr), 64'd0);
  endtask

  initial begin
    logic [14:0] exp_wrap [4];
    int          b0, k;
    reset = 1'b1; start = 1'b0; mode = '0; base_addr = '0; word_count = '0; seed = '0;
    for (int i = 0; i < 8192; i++) xmask[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Fill then verify, zero-wait slave, latency 1.
    start_op(2'd1, 15'h0100, 16, 32'h12345678);
    wait_done("fv_nowait");
    check_op("fv_nowait");
    check_eq("fv_nowait_word0", 64'(mem[15'h0100 >> 2]), 64'h12345678);
    check_eq("fv_nowait_word1", 64'(mem[(15'h0100 >> 2) + 1]), 64'hEDCBA986);
    check_eq("fv_nowait_first_req", 64'(first_req_edge), 64'(s_cyc + 1));
    check_eq("fv_nowait_done_cyc", 64'(d_cyc), 64'(s_cyc + 2 * 16 + 2));

    // Same with stalls and variable read latency.
    wait_pct = 50; lat_min = 1; lat_max = 3;
    start_op(2'd1, 15'h0100, 16, 32'h12345678);
    wait_done("fv_stall");
    check_op("fv_stall");

    // Verify only, two corrupted words.
    xmask[(15'h0100 >> 2) + 5] = 32'h0000_0001;
    xmask[(15'h0100 >> 2) + 9] = 32'h8000_0000;
    start_op(2'd2, 15'h0100, 16, 32'h12345678);
    wait_done("verify_bad");
    check_op("verify_bad");
    check_eq("verify_bad_count2", 64'(error_count), 64'd2);
    check_eq("verify_bad_addr", 64'(first_err_addr), 64'h0114);
    for (int i = 0; i < 8192; i++) xmask[i] = '0;

    // Address wrap at the top of the space.
    start_op(2'd1, 15'h7FF8, 4, 32'hCAFE0000);
    wait_done("wrap");
    check_op("wrap");
    exp_wrap = '{15'h7FF8, 15'h7FFC, 15'h0000, 15'h0004};
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++)
      check_eq("wrap_addr", 64'(wr_addr_q[i]), 64'(exp_wrap[i]));

    // Zero-length request.
    start_op(2'd1, 15'h0300, 0, 32'h11111111);
    wait_done("zero");
    check_op("zero");
    check_eq("zero_done_cyc", 64'(d_cyc), 64'(s_cyc + 1));
    check_eq("zero_bus", 64'(bus_cycles), 64'd0);

    // Start while busy is ignored.
    wait_pct = 0; lat_max = 1;
    start_op(2'd0, 15'h0200, 8, 32'hA5A50000);
    @(posedge clk); #1;
    mode = 2'd2; base_addr = 15'h0400; word_count = 14'd3; seed = 32'h0BAD0BAD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_start");
    check_op("busy_start");
    repeat (5) @(negedge clk);
    check_eq("busy_start_quiet", 64'(busy), 64'd0);
    check_eq("busy_start_bus", 64'(bus_cycles), 64'd8);

    // Randomized operations.
    for (int r = 0; r < 6; r++) begin
      logic [1:0]  m;
      logic [14:0] b, a;
      int          n;
      m = 2'($urandom_range(3, 0));
      b = 15'($urandom);
      n = $urandom_range(40, 1);
      wait_pct = $urandom_range(60, 0);
      lat_max = $urandom_range(3, 1);
      for (int c = 0; c < 3; c++) begin
        a = waddr(b, $urandom_range(n - 1, 0));
        xmask[a[14:2]] = 32'h1 << $urandom_range(31, 0);
      end
      start_op(m, b, n, $urandom);
      wait_done("rand");
      check_op("rand");
      for (int i = 0; i < 8192; i++) xmask[i] = '0;
    end

    // Reset with reads in flight; late responses carry bad data.
    wait_pct = 0; lat_min = 3; lat_max = 3;
    for (int i = 0; i < 40; i++) xmask[i] = 32'hFFFF_FFFF;
    start_op(2'd2, 15'h0000, 40, 32'h5555AAAA);
    k = 0;
    while (rd_addr_q.size() < 6 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq("rst_mid_reads_started", 64'(rd_addr_q.size() >= 6), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("rst_mid");
    b0 = bus_cycles;
    repeat (8) @(negedge clk);
    check_eq("rst_late_err", 64'(error_count), 64'd0);
    check_eq("rst_late_valid", 64'(first_err_valid), 64'd0);
    check_eq("rst_no_requests", 64'(bus_cycles), 64'(b0));
    for (int i = 0; i < 40; i++) xmask[i] = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
